// File: rtl/gb_lcd_fb_writer.sv
// Game Boy LCD pixel stream to double-buffered 160x144 RGB555 framebuffer writer.
// A small show-ahead FIFO decouples the core strobe from framebuffer back-pressure.
module gb_lcd_fb_writer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [14:0] BLANK_COLOR = 15'h7FFF
) (
  input  logic        hclk,
  input  logic        reset,
  input  logic        lcd_clkena,
  input  logic [14:0] lcd_data,
  input  logic [1:0]  lcd_mode,
  input  logic        lcd_on,
  input  logic        lcd_vsync,
  input  logic        fb_ready,
  input  logic        err_clr,
  output logic        fb_we,
  output logic [15:0] fb_addr,
  output logic [14:0] fb_wdata,
  output logic        display_bank,
  output logic        frame_done,
  output logic        drop_err,
  output logic        frame_err
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW+1)'(FIFO_DEPTH);
  localparam logic [14:0] FramePix = 15'd23040;
  localparam logic [14:0] LastPix  = 15'd23039;

  typedef enum logic [1:0] {StIdle, StActive, StBlank, StOff} state_e;

  state_e      state_q, state_d;
  logic        vsync_q;
  logic        wbank_q, wbank_d;
  logic        display_bank_q, display_bank_d;
  logic        pend_q, pend_d;
  logic        pend_bank_q, pend_bank_d;
  logic        frame_done_q, frame_done_d;
  logic        drop_err_q, drop_err_d;
  logic        frame_err_q, frame_err_d;
  logic [14:0] pix_cnt_q, pix_cnt_d, pix_cnt_inc;
  logic [14:0] blank_addr_q, blank_addr_d;

  logic [30:0]     mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic [30:0]     head;

  logic vsync_rise, fifo_empty, fifo_full, blank_wr, xfer, pop;
  logic accept, take, push, drop, frame_set, pend_set, full_frame;

  assign vsync_rise = lcd_vsync & ~vsync_q;
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DepthCnt);
  assign head       = mem[rd_ptr_q];

  // Blank writes only start once every queued pixel has left the FIFO.
  assign blank_wr = (state_q == StBlank) & fifo_empty;
  assign fb_we    = ~fifo_empty | blank_wr;
  assign xfer     = fb_we & fb_ready;
  assign pop      = xfer & ~fifo_empty;

  assign accept = lcd_clkena & (lcd_mode == 2'd3) & lcd_on & (state_q == StActive);
  assign take   = accept & (pix_cnt_q != FramePix);
  assign push   = take & (~fifo_full | pop);
  assign drop   = take & fifo_full & ~pop;

  assign pix_cnt_inc = take ? pix_cnt_q + 15'd1 : pix_cnt_q;
  assign full_frame  = (pix_cnt_inc == FramePix);

  always_comb begin
    fb_addr  = '0;
    fb_wdata = '0;
    if (!fifo_empty) begin
      fb_addr  = head[30:15];
      fb_wdata = head[14:0];
    end else if (blank_wr) begin
      fb_addr  = {wbank_q, blank_addr_q};
      fb_wdata = BLANK_COLOR;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    wbank_d        = wbank_q;
    display_bank_d = display_bank_q;
    pend_d         = pend_q;
    pend_bank_d    = pend_bank_q;
    frame_done_d   = 1'b0;
    pix_cnt_d      = pix_cnt_inc;
    blank_addr_d   = blank_addr_q;
    frame_set      = accept & ~take;
    pend_set       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (lcd_on && vsync_rise) begin
          state_d   = StActive;
          pix_cnt_d = '0;
        end
      end
      StActive: begin
        if (!lcd_on) begin
          state_d      = StBlank;
          blank_addr_d = '0;
        end else if (vsync_rise) begin
          pix_cnt_d = '0;
          if (full_frame) begin
            wbank_d  = ~wbank_q;
            pend_set = 1'b1;
          end else begin
            frame_set = 1'b1;
          end
        end
      end
      StBlank: begin
        if (blank_wr && fb_ready) begin
          if (blank_addr_q == LastPix) begin
            display_bank_d = wbank_q;
            wbank_d        = ~wbank_q;
            frame_done_d   = 1'b1;
            pend_d         = 1'b0;
            state_d        = lcd_on ? StIdle : StOff;
          end else begin
            blank_addr_d = blank_addr_q + 15'd1;
          end
        end
      end
      StOff: begin
        if (lcd_on) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Publish the completed bank once its last write leaves this cycle.
    if ((pend_q || pend_set) && (cnt_d == '0) && !blank_wr) begin
      display_bank_d = pend_set ? wbank_q : pend_bank_q;
      frame_done_d   = 1'b1;
      pend_d         = 1'b0;
    end else if (pend_set) begin
      pend_d      = 1'b1;
      pend_bank_d = wbank_q;
    end

    drop_err_d  = drop      ? 1'b1 : (err_clr ? 1'b0 : drop_err_q);
    frame_err_d = frame_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
  end

  always_ff @(posedge hclk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      vsync_q        <= 1'b0;
      wbank_q        <= 1'b1;
      display_bank_q <= 1'b0;
      pend_q         <= 1'b0;
      pend_bank_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      drop_err_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      pix_cnt_q      <= '0;
      blank_addr_q   <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      vsync_q        <= lcd_vsync;
      wbank_q        <= wbank_d;
      display_bank_q <= display_bank_d;
      pend_q         <= pend_d;
      pend_bank_q    <= pend_bank_d;
      frame_done_q   <= frame_done_d;
      drop_err_q     <= drop_err_d;
      frame_err_q    <= frame_err_d;
      pix_cnt_q      <= pix_cnt_d;
      blank_addr_q   <= blank_addr_d;
      cnt_q          <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (push) mem[wr_ptr_q] <= {wbank_q, pix_cnt_q, lcd_data};
  end

  assign display_bank = display_bank_q;
  assign frame_done   = frame_done_q;
  assign drop_err     = drop_err_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_gb_lcd_fb_writer.sv
// Scoreboard bench for gb_lcd_fb_writer: expected writes queued at stimulus time,
// popped and compared on every framebuffer transfer.
module tb_gb_lcd_fb_writer;

  logic        hclk = 1'b0;
  logic        reset = 1'b1;
  logic        lcd_clkena = 1'b0;
  logic [14:0] lcd_data = '0;
  logic [1:0]  lcd_mode = 2'd3;
  logic        lcd_on = 1'b0;
  logic        lcd_vsync = 1'b0;
  logic        fb_ready = 1'b1;
  logic        err_clr = 1'b0;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [14:0] fb_wdata;
  logic        display_bank;
  logic        frame_done;
  logic        drop_err;
  logic        frame_err;

  gb_lcd_fb_writer #(.FIFO_DEPTH(4), .BLANK_COLOR(15'h7FFF)) dut (
    .hclk         (hclk),
    .reset        (reset),
    .lcd_clkena   (lcd_clkena),
    .lcd_data     (lcd_data),
    .lcd_mode     (lcd_mode),
    .lcd_on       (lcd_on),
    .lcd_vsync    (lcd_vsync),
    .fb_ready     (fb_ready),
    .err_clr      (err_clr),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_wdata     (fb_wdata),
    .display_bank (display_bank),
    .frame_done   (frame_done),
    .drop_err     (drop_err),
    .frame_err    (frame_err)
  );

  always #5 hclk = ~hclk;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [30:0] exp_q[$];
  logic        hold_valid = 1'b0;
  logic [30:0] hold_val = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transfers happen at the next posedge; sampled here on the falling edge.
  always @(negedge hclk) begin
    if (reset) begin
      hold_valid = 1'b0;
    end else begin
      if (fb_we && hold_valid) check_eq("hold_stable", {1'b0, fb_addr, fb_wdata}, {1'b0, hold_val});
      if (fb_we && fb_ready) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", {1'b0, fb_addr, fb_wdata}, 32'hFFFF_FFFF);
        end else begin
          check_eq("write", {1'b0, fb_addr, fb_wdata}, {1'b0, exp_q.pop_front()});
        end
      end
      hold_valid = fb_we && !fb_ready;
      hold_val   = {fb_addr, fb_wdata};
      if (frame_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic pulse_vsync();
    lcd_vsync = 1'b1;
    tick();
    lcd_vsync = 1'b0;
    tick();
  endtask

  // Strobe one pixel; queue its write when keep is set.
  task automatic strobe(input logic bank, input int idx, input bit keep);
    logic [14:0] a;
    a = idx[14:0];
    lcd_clkena = 1'b1;
    lcd_data   = a;
    if (keep) exp_q.push_back({bank, a, a});
    tick();
    lcd_clkena = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, idx;
    logic [14:0] a;

    repeat (3) tick();
    check_eq("rst_fb_we", fb_we, 0);
    check_eq("rst_fb_addr", fb_addr, 0);
    check_eq("rst_fb_wdata", fb_wdata, 0);
    check_eq("rst_display_bank", display_bank, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_errs", {drop_err, frame_err}, 0);
    reset = 1'b0;
    lcd_on = 1'b1;
    tick();

    // Frame A: full frame into bank 1, fb_ready tied high.
    pulse_vsync();
    for (int i = 0; i < 23040; i++) begin
      a = i[14:0];
      lcd_clkena = 1'b1;
      lcd_data   = a;
      exp_q.push_back({1'b1, a, a});
      tick();
    end
    lcd_clkena = 1'b0;
    wait_drain("drain_frame_a", 20);
    check_eq("no_done_before_vsync", done_cnt, 0);
    d0 = done_cnt;
    pulse_vsync();
    repeat (3) tick();
    check_eq("done_frame_a", done_cnt - d0, 1);
    check_eq("disp_after_a", display_bank, 1);
    check_eq("frame_err_a", frame_err, 0);

    // Frame B (bank 0): back-pressure, strobe every 4th cycle, ready 1 of 3.
    idx = 0;
    for (int c = 0; c < 240; c++) begin
      fb_ready = (c % 3 == 0);
      if (c % 4 == 0) begin
        a = idx[14:0];
        lcd_clkena = 1'b1;
        lcd_data   = a;
        exp_q.push_back({1'b0, a, a});
        idx++;
      end
      tick();
      lcd_clkena = 1'b0;
    end
    fb_ready = 1'b1;
    wait_drain("drain_backpressure", 40);
    check_eq("no_drop_backpressure", drop_err, 0);

    // Overflow: ready low for 10 strobes, 4 kept and 6 dropped.
    fb_ready = 1'b0;
    w0 = wr_cnt;
    for (int k = 0; k < 10; k++) begin
      strobe(1'b0, idx, k < 4);
      idx++;
    end
    tick();
    check_eq("drop_err_set", drop_err, 1);
    fb_ready = 1'b1;
    wait_drain("drain_overflow", 20);
    check_eq("overflow_kept", wr_cnt - w0, 4);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("drop_err_clr", drop_err, 0);

    // Short frame: no swap, error flagged.
    d0 = done_cnt;
    pulse_vsync();
    repeat (3) tick();
    check_eq("frame_err_short", frame_err, 1);
    check_eq("no_done_short", done_cnt - d0, 0);
    check_eq("disp_after_short", display_bank, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("frame_err_clr", frame_err, 0);

    // Frame C stays in bank 0; a non-mode-3 strobe is ignored.
    lcd_mode = 2'd2;
    strobe(1'b0, 999, 0);
    lcd_mode = 2'd3;
    for (int i = 0; i < 20; i++) strobe(1'b0, i, 1);
    wait_drain("drain_frame_c", 20);
    fb_ready = 1'b0;
    for (int i = 20; i < 23; i++) strobe(1'b0, i, 1);

    // LCD off with 3 queued: drain, blank bank 0, swap.
    d0 = done_cnt;
    lcd_on = 1'b0;
    for (int i = 0; i < 23040; i++) begin
      a = i[14:0];
      exp_q.push_back({1'b0, a, 15'h7FFF});
    end
    tick();
    fb_ready = 1'b1;
    wait_drain("drain_blank", 23200);
    repeat (2) tick();
    check_eq("done_blank", done_cnt - d0, 1);
    check_eq("disp_after_blank", display_bank, 0);
    w0 = wr_cnt;
    repeat (20) tick();
    check_eq("no_writes_off", wr_cnt - w0, 0);
    check_eq("fb_we_off", fb_we, 0);

    // Resume: next frame lands in bank 1.
    lcd_on = 1'b1;
    tick();
    pulse_vsync();
    for (int i = 0; i < 5; i++) strobe(1'b1, i, 1);
    wait_drain("drain_resume", 20);

    // Reset while a write is stalled.
    fb_ready = 1'b0;
    for (int i = 5; i < 11; i++) strobe(1'b1, i, i < 9);
    tick();
    check_eq("we_before_reset", fb_we, 1);
    check_eq("drop_before_reset", drop_err, 1);
    reset = 1'b1;
    #1;
    check_eq("reset_fb_we", fb_we, 0);
    check_eq("reset_fb_addr", fb_addr, 0);
    check_eq("reset_fb_wdata", fb_wdata, 0);
    check_eq("reset_flags", {display_bank, frame_done, drop_err, frame_err}, 0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    fb_ready = 1'b1;
    tick();
    pulse_vsync();
    for (int i = 0; i < 3; i++) strobe(1'b1, i, 1);
    wait_drain("drain_after_reset", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
